// File: rtl/clk_pkg.sv
// Shared constants and helpers for the modulo counter and its prescaler.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package clk_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Prescaler register width: clog2 of the division ratio, never below one bit.
  function automatic int calc_pw(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/clk_mod_counter_if.sv
// Control and status bundle between a counter client and clk_mod_counter.
// Latency: n/a (wires only).
// Backpressure: none; en gates progress, nothing stalls the client.
interface clk_mod_counter_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] mod_max;
  logic             flag_clr;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             tc;
  logic             wrap_flag;

  modport master (
    output en, up, load, load_value, mod_max, flag_clr,
    input  count, tick, tc, wrap_flag
  );

  modport slave (
    input  en, up, load, load_value, mod_max, flag_clr,
    output count, tick, tc, wrap_flag
  );
endinterface

// File: rtl/clk_prescaler.sv
// Divides the enable stream: tick once per PRESCALE enabled clocks.
// Latency: tick is combinational from en and the registered phase.
// Backpressure: none; phase holds while en is low, clr restarts it.
module clk_prescaler
  import clk_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = calc_pw(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign tick = en && (pre_q == LAST);

  // Next phase: restart on clr, advance on en, fold back to 0 on the tick.
  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
  end

  // Phase register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
endmodule

// File: rtl/clk_mod_counter.sv
// Up/down modulo counter with prescaled enable, load, terminal-count pulse and sticky wrap flag.
// Latency: one clock from tick to count update; tc is registered alongside the wrapped count.
// Backpressure: none; priority per clock is reset, then load, then count step.
module clk_mod_counter
  import clk_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              reset,
  clk_mod_counter_if.slave  bus
);
  logic             tick;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             flag_q;
  logic             wrap;

  // A load restarts the prescaler phase so the next step is a full period away.
  clk_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .clr   (bus.load),
    .tick  (tick)
  );

  assign bus.tick      = tick;
  assign bus.count     = count_q;
  assign bus.tc        = tc_q;
  assign bus.wrap_flag = flag_q;

  // Step value: wrap at the modulus boundary; an out-of-range count going down snaps to mod_max.
  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (tick) begin
      if (bus.up == DIR_UP) begin
        if (count_q >= bus.mod_max) begin
          count_d = '0;
          wrap    = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = bus.mod_max;
          wrap    = 1'b1;
        end else if (count_q > bus.mod_max) begin
          count_d = bus.mod_max;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // State update: load overrides any tick; a wrap beats flag_clr on the sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else if (bus.load) begin
      count_q <= bus.load_value;
      tc_q    <= 1'b0;
      flag_q  <= flag_q & ~bus.flag_clr;
    end else begin
      count_q <= count_d;
      tc_q    <= wrap;
      flag_q  <= wrap | (flag_q & ~bus.flag_clr);
    end
  end
endmodule
